// File: rtl/qq_ctrl.sv
// qq_ctrl: front-end controller for a chained min-priority queue.
// Accepts enqueue/dequeue requests, issues single-cycle pulses to the head
// node, tracks occupancy and returns dequeued keys to the client.
// Optional build macro QQ_CTRL_STATS_EN adds saturating event counters
// (enq_cnt, deq_cnt, drop_cnt).
module qq_ctrl #(
  parameter int unsigned W = 32,
  parameter int unsigned D = 4,
  parameter int unsigned N = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  input  logic                        req_op,
  input  logic [W-1:0]                req_key,
  output logic                        req_ready,
  output logic                        rsp_valid,
  output logic [W-1:0]                rsp_key,
  output logic                        rsp_err,
  input  logic                        rsp_ready,
  output logic                        enq_o,
  output logic                        deq_o,
  output logic [W-1:0]                key_o,
  input  logic                        node_idle_i,
  input  logic [W-1:0]                head_key_i,
  output logic [$clog2(N*D+1)-1:0]    count_o,
  output logic                        full_o,
  output logic                        empty_o,
`ifdef QQ_CTRL_STATS_EN
  output logic [15:0]                 enq_cnt,
  output logic [15:0]                 deq_cnt,
  output logic [15:0]                 drop_cnt,
`endif
  output logic                        drop_o
);

  localparam int unsigned C  = N * D;
  localparam int unsigned CW = $clog2(C + 1);
  localparam logic [W-1:0] MAX_KEY = {W{1'b1}};

  typedef enum logic [2:0] {
    INIT, IDLE, ISSUE_ENQ, ISSUE_DEQ, WAIT, RESP
  } state_t;

  state_t         state, state_next;
  logic           op_deq, op_deq_nx;
  logic           req_ready_nx, rsp_valid_nx, rsp_err_nx;
  logic [W-1:0]   rsp_key_nx, key_nx;
  logic           enq_nx, deq_nx, drop_nx, full_nx, empty_nx;
  logic [CW-1:0]  count_nx;
  logic           enq_ok;

  // Enqueue admissible: room left and key is not the reserved sentinel
  assign enq_ok = (count_o < CW'(C)) && (req_key != MAX_KEY);

  // State register plus all registered outputs (loaded from look-ahead values)
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      op_deq    <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_key   <= '0;
      rsp_err   <= 1'b0;
      enq_o     <= 1'b0;
      deq_o     <= 1'b0;
      key_o     <= '0;
      drop_o    <= 1'b0;
      count_o   <= '0;
      full_o    <= 1'b0;
      empty_o   <= 1'b1;
    end else begin
      state     <= state_next;
      op_deq    <= op_deq_nx;
      req_ready <= req_ready_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_key   <= rsp_key_nx;
      rsp_err   <= rsp_err_nx;
      enq_o     <= enq_nx;
      deq_o     <= deq_nx;
      key_o     <= key_nx;
      drop_o    <= drop_nx;
      count_o   <= count_nx;
      full_o    <= full_nx;
      empty_o   <= empty_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      INIT:      if (node_idle_i) state_next = IDLE;
      IDLE: begin
        if (req_valid) begin
          if (!req_op) begin
            if (enq_ok) state_next = ISSUE_ENQ;
          end else begin
            state_next = (count_o != '0) ? ISSUE_DEQ : RESP;
          end
        end
      end
      ISSUE_ENQ: state_next = WAIT;
      ISSUE_DEQ: state_next = WAIT;
      WAIT:      if (node_idle_i) state_next = op_deq ? RESP : IDLE;
      RESP:      if (rsp_ready) state_next = IDLE;
      default:   state_next = INIT;
    endcase
  end

  // Output/datapath look-ahead: values the output registers take next cycle
  always_comb begin
    req_ready_nx = (state_next == IDLE);
    rsp_valid_nx = (state_next == RESP);
    enq_nx       = (state_next == ISSUE_ENQ);
    deq_nx       = (state_next == ISSUE_DEQ);
    key_nx       = '0;
    drop_nx      = 1'b0;
    rsp_key_nx   = rsp_key;
    rsp_err_nx   = rsp_err;
    count_nx     = count_o;
    op_deq_nx    = op_deq;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          op_deq_nx = req_op;
          if (!req_op) begin
            if (enq_ok) key_nx = req_key;
            else        drop_nx = 1'b1;
          end else if (count_o == '0) begin
            rsp_key_nx = MAX_KEY;
            rsp_err_nx = 1'b1;
          end
        end
      end
      ISSUE_ENQ: begin
        if (count_o != CW'(C)) count_nx = count_o + CW'(1);
      end
      ISSUE_DEQ: begin
        rsp_key_nx = head_key_i;
        rsp_err_nx = 1'b0;
        if (count_o != '0) count_nx = count_o - CW'(1);
      end
      default: ;
    endcase
    full_nx  = (count_nx == CW'(C));
    empty_nx = (count_nx == '0);
  end

`ifdef QQ_CTRL_STATS_EN
  // Saturating event counters for issued operations and drops
  always_ff @(posedge clk) begin
    if (rst) begin
      enq_cnt  <= '0;
      deq_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (enq_o  && (enq_cnt  != 16'hFFFF)) enq_cnt  <= enq_cnt  + 16'd1;
      if (deq_o  && (deq_cnt  != 16'hFFFF)) deq_cnt  <= deq_cnt  + 16'd1;
      if (drop_o && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_qq_ctrl.sv
// tb_qq_ctrl: directed + randomized bench for qq_ctrl (N=1, D=4, capacity 4).
// A sorted head-node model sits behind the DUT; a transaction-level
// reference queue predicts occupancy, drops and dequeued keys.
module tb_qq_ctrl;
  localparam int unsigned W  = 32;
  localparam int unsigned D  = 4;
  localparam int unsigned N  = 1;
  localparam int unsigned C  = N * D;
  localparam int unsigned CW = $clog2(C + 1);
  localparam logic [W-1:0] MAX_KEY = '1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_op, req_ready;
  logic [W-1:0]  req_key;
  logic          rsp_valid, rsp_err, rsp_ready;
  logic [W-1:0]  rsp_key;
  logic          enq_o, deq_o;
  logic [W-1:0]  key_o;
  logic          node_idle_i;
  logic [W-1:0]  head_key_i;
  logic [CW-1:0] count_o;
  logic          full_o, empty_o, drop_o;

  qq_ctrl #(.W(W), .D(D), .N(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_key(req_key), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_key(rsp_key), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .enq_o(enq_o), .deq_o(deq_o), .key_o(key_o),
    .node_idle_i(node_idle_i), .head_key_i(head_key_i),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o), .drop_o(drop_o)
  );

  always #5 clk = ~clk;

  // Head node model: sorted storage, random busy time after each pulse
  logic [W-1:0] node_q[$];
  int           busy;
  int           p;
  logic         node_idle_r;
  logic         force_busy;
  assign node_idle_i = node_idle_r & ~force_busy;

  always @(posedge clk) begin
    if (rst) begin
      node_q.delete();
      busy = 0;
      node_idle_r <= 1'b1;
      head_key_i  <= MAX_KEY;
    end else begin
      if (enq_o) begin
        p = 0;
        while (p < node_q.size() && node_q[p] <= key_o) p++;
        node_q.insert(p, key_o);
      end
      if (deq_o && node_q.size() > 0) void'(node_q.pop_front());
      if (enq_o || deq_o) busy = $urandom_range(0, 3);
      else if (busy > 0) busy--;
      node_idle_r <= (busy == 0);
      head_key_i  <= (node_q.size() != 0) ? node_q[0] : MAX_KEY;
    end
  end

  // Reference: unordered multiset of stored keys; dequeue returns the minimum
  logic [W-1:0] ref_q[$];
  logic [W-1:0] last_rsp;
  int n_pass = 0, n_total = 0, n_fail = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    check("ready_wait", W'(n < 40), 1);
  endtask

  task automatic do_req(input logic op, input logic [W-1:0] key, input int hold);
    int n, mi;
    logic [W-1:0] exp_key;
    logic exp_err;
    wait_ready();
    check("count", W'(count_o), W'(ref_q.size()));
    check("empty", W'(empty_o), W'(ref_q.size() == 0));
    check("full",  W'(full_o),  W'(ref_q.size() == int'(C)));
    req_valid = 1'b1; req_op = op; req_key = key;
    @(negedge clk);
    req_valid = 1'b0; req_op = 1'b0; req_key = '0;
    if (!op) begin
      if (ref_q.size() < int'(C) && key != MAX_KEY) begin
        ref_q.push_back(key);
        check("enq_pulse", W'(enq_o), 1);
        check("enq_key", key_o, key);
        check("enq_no_deq", W'(deq_o), 0);
        check("enq_no_drop", W'(drop_o), 0);
        @(negedge clk);
        check("enq_once", W'(enq_o), 0);
        check("key_zero", key_o, 0);
      end else begin
        check("drop_pulse", W'(drop_o), 1);
        check("drop_no_enq", W'(enq_o), 0);
        check("drop_ready", W'(req_ready), 1);
        @(negedge clk);
        check("drop_once", W'(drop_o), 0);
        check("drop_no_enq2", W'(enq_o), 0);
      end
    end else begin
      if (ref_q.size() > 0) begin
        mi = 0;
        for (int i = 1; i < ref_q.size(); i++) if (ref_q[i] < ref_q[mi]) mi = i;
        exp_key = ref_q[mi];
        ref_q.delete(mi);
        exp_err = 1'b0;
        check("deq_pulse", W'(deq_o), 1);
        check("deq_no_enq", W'(enq_o), 0);
        check("deq_early_rsp", W'(rsp_valid), 0);
        @(negedge clk);
        check("deq_once", W'(deq_o), 0);
        check("deq_early_rsp2", W'(rsp_valid), 0);
      end else begin
        exp_key = MAX_KEY;
        exp_err = 1'b1;
        check("deq_empty_nopulse", W'(deq_o), 0);
        check("deq_empty_resp", W'(rsp_valid), 1);
      end
      n = 0;
      while (rsp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      check("rsp_wait", W'(n < 40), 1);
      check("rsp_key", rsp_key, exp_key);
      check("rsp_err", W'(rsp_err), W'(exp_err));
      last_rsp = rsp_key;
      repeat (hold) begin
        @(negedge clk);
        check("rsp_hold_valid", W'(rsp_valid), 1);
        check("rsp_hold_key", rsp_key, exp_key);
        check("rsp_hold_ready", W'(req_ready), 0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("rsp_done", W'(rsp_valid), 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [W-1:0] k;
    rst = 1'b1; force_busy = 1'b1;
    req_valid = 1'b0; req_op = 1'b0; req_key = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", W'(req_ready), 0);
    check("rst_count", W'(count_o), 0);
    check("rst_empty", W'(empty_o), 1);
    check("rst_full",  W'(full_o), 0);
    check("rst_rsp_valid", W'(rsp_valid), 0);
    check("rst_rsp_err", W'(rsp_err), 0);
    check("rst_rsp_key", rsp_key, 0);
    check("rst_enq", W'(enq_o), 0);
    check("rst_deq", W'(deq_o), 0);
    check("rst_key", key_o, 0);
    check("rst_drop", W'(drop_o), 0);

    // Node busy for 6 cycles after reset: controller stays in INIT
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("init_ready", W'(req_ready), 0);
    end
    force_busy = 1'b0;
    @(negedge clk);
    check("init_exit_ready", W'(req_ready), 1);
    check("init_exit_count", W'(count_o), 0);
    check("init_exit_empty", W'(empty_o), 1);

    // Sorted dequeue order
    do_req(1'b0, 32'h30, 0);
    do_req(1'b0, 32'h10, 0);
    do_req(1'b0, 32'h20, 0);
    do_req(1'b1, '0, 1); check("sort_0", last_rsp, 32'h10);
    do_req(1'b1, '0, 0); check("sort_1", last_rsp, 32'h20);
    do_req(1'b1, '0, 2); check("sort_2", last_rsp, 32'h30);
    wait_ready();
    check("sort_empty", W'(empty_o), 1);

    // Fill to capacity, fifth enqueue dropped
    repeat (5) do_req(1'b0, 32'h5, 0);
    wait_ready();
    check("cap_count", W'(count_o), 4);
    check("cap_full", W'(full_o), 1);
    repeat (4) do_req(1'b1, '0, 0);

    // Empty dequeue and reserved key
    do_req(1'b1, '0, 1);
    check("empty_deq_key", last_rsp, 32'hFFFFFFFF);
    do_req(1'b0, MAX_KEY, 0);

    // Held response interrupted by reset
    do_req(1'b0, 32'h77, 0);
    wait_ready();
    req_valid = 1'b1; req_op = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; req_op = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    check("hold_rsp_wait", W'(n < 40), 1);
    repeat (2) begin
      @(negedge clk);
      check("hold_valid", W'(rsp_valid), 1);
      check("hold_key", rsp_key, 32'h77);
      check("hold_ready", W'(req_ready), 0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", W'(rsp_valid), 0);
    check("mid_rst_ready", W'(req_ready), 0);
    check("mid_rst_count", W'(count_o), 0);
    check("mid_rst_empty", W'(empty_o), 1);
    check("mid_rst_key", rsp_key, 0);
    ref_q.delete();
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      k = ($urandom_range(0, 7) == 0) ? MAX_KEY : W'($urandom_range(0, 255));
      do_req(1'($urandom_range(0, 1)), k, $urandom_range(0, 3));
    end
    wait_ready();
    check("final_count", W'(count_o), W'(ref_q.size()));

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
